// File: rtl/state_display_mux.sv
// Time-multiplexed 7-segment driver with double-buffered digit values, per-digit blank/blink,
// anode dead-time at the start of each slot, and a one-cycle frame strobe.
module state_display_mux #(
    parameter int N_DIGITS     = 4,
    parameter int STATE_W      = 2,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [N_DIGITS*STATE_W-1:0]  state_in,
    input  logic [N_DIGITS-1:0]          blank_mask,
    input  logic [N_DIGITS-1:0]          blink_mask,
    output logic [7:0]                   seg,
    output logic [N_DIGITS-1:0]          digit_en,
    output logic                         frame_done
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0]    IDX_MAX  = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0]    FRM_MAX  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]          SEG_OFF  = {8{ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] EN_OFF   = {N_DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [FRM_W-1:0]            frm_reg;
    logic                        hidden_reg;
    logic                        pending_reg;
    logic [N_DIGITS*STATE_W-1:0] act_state_reg, sh_state_reg;
    logic [N_DIGITS-1:0]         act_blank_reg, sh_blank_reg;
    logic [N_DIGITS-1:0]         act_blink_reg, sh_blink_reg;
    logic [7:0]                  seg_reg, seg_next;
    logic [N_DIGITS-1:0]         digit_en_reg, en_next;
    logic                        frame_done_reg;

    logic                        cnt_wrap, frame_wrap;
    logic [N_DIGITS-1:0]         sel;
    logic [3:0]                  act_val [N_DIGITS];
    logic [3:0]                  cur_val;
    logic                        cur_blank, cur_blink;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign act_val[gi] = 4'(act_state_reg[gi*STATE_W +: STATE_W]);
            assign sel[gi]     = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        cur_val   = 4'h0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (sel[k]) begin
                cur_val   = act_val[k];
                cur_blank = act_blank_reg[k];
                cur_blink = act_blink_reg[k];
            end
        end
    end

    always_comb begin
        cnt_wrap   = (cnt_reg == CNT_MAX);
        frame_wrap = cnt_wrap && (idx_reg == IDX_MAX);
        cnt_next   = cnt_wrap ? '0 : cnt_reg + 1'b1;
        idx_next   = idx_reg;
        if (cnt_wrap) begin
            idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
        end
    end

    // A blanked digit keeps its anode off so a never-loaded display stays fully dark;
    // a blinking digit keeps its anode on and only drops the segments.
    always_comb begin
        seg_next = SEG_OFF;
        en_next  = EN_OFF;
        if (cnt_reg >= CNT_DEAD && !cur_blank) begin
            en_next = ACTIVE_LOW ? ~sel : sel;
            if (!(cur_blink && hidden_reg)) begin
                seg_next = ACTIVE_LOW ? ~{1'b0, glyph(cur_val)} : {1'b0, glyph(cur_val)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            frm_reg        <= '0;
            hidden_reg     <= 1'b0;
            pending_reg    <= 1'b0;
            act_state_reg  <= '0;
            sh_state_reg   <= '0;
            act_blank_reg  <= '1;
            sh_blank_reg   <= '1;
            act_blink_reg  <= '0;
            sh_blink_reg   <= '0;
            seg_reg        <= SEG_OFF;
            digit_en_reg   <= EN_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            seg_reg        <= seg_next;
            digit_en_reg   <= en_next;
            frame_done_reg <= frame_wrap;
            if (load) begin
                sh_state_reg <= state_in;
                sh_blank_reg <= blank_mask;
                sh_blink_reg <= blink_mask;
            end
            // Commit only at the frame boundary; a load on that very edge goes straight through.
            if (frame_wrap) begin
                pending_reg <= 1'b0;
                if (load) begin
                    act_state_reg <= state_in;
                    act_blank_reg <= blank_mask;
                    act_blink_reg <= blink_mask;
                end else if (pending_reg) begin
                    act_state_reg <= sh_state_reg;
                    act_blank_reg <= sh_blank_reg;
                    act_blink_reg <= sh_blink_reg;
                end
                if (frm_reg == FRM_MAX) begin
                    frm_reg    <= '0;
                    hidden_reg <= ~hidden_reg;
                end else begin
                    frm_reg <= frm_reg + 1'b1;
                end
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign seg        = seg_reg;
    assign digit_en   = digit_en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_state_display_mux.sv
// Bench for state_display_mux: a 4-digit active-low instance driven against a cycle model,
// and a 1-digit active-high instance for the single-digit case.
module tb_state_display_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       load_a = 1'b0;
    logic [7:0] state_a = '0;
    logic [3:0] blank_a = '0;
    logic [3:0] blink_a = '0;
    logic [7:0] seg_a;
    logic [3:0] en_a;
    logic       fd_a;

    logic       load_b = 1'b0;
    logic [3:0] state_b = '0;
    logic [0:0] blank_b = '0;
    logic [0:0] blink_b = '0;
    logic [7:0] seg_b;
    logic [0:0] en_b;
    logic       fd_b;

    state_display_mux #(
        .N_DIGITS(4), .STATE_W(2), .SCAN_DIV(8), .DEAD(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .state_in(state_a),
        .blank_mask(blank_a), .blink_mask(blink_a),
        .seg(seg_a), .digit_en(en_a), .frame_done(fd_a)
    );

    state_display_mux #(
        .N_DIGITS(1), .STATE_W(4), .SCAN_DIV(8), .DEAD(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .state_in(state_b),
        .blank_mask(blank_b), .blink_mask(blink_b),
        .seg(seg_b), .digit_en(en_b), .frame_done(fd_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Spec-level model of the 4-digit instance: committed and shadow contents.
    logic [1:0]  m_act [4];
    logic [1:0]  m_sh  [4];
    logic [3:0]  m_act_blank, m_act_blink, m_sh_blank, m_sh_blink;
    bit          m_pend;
    logic [12:0] sb_a [$];
    logic [9:0]  sb_b [$];

    logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [3:0] en_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_tab [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 2'd0;
            m_sh[i]  = 2'd0;
        end
        m_act_blank = 4'hF;
        m_sh_blank  = 4'hF;
        m_act_blink = 4'h0;
        m_sh_blink  = 4'h0;
        m_pend      = 1'b0;
        sb_a.delete();
        sb_b.delete();
    endtask

    // Predicts the 4-digit outputs for the coming edge, updates the model, advances one clock.
    task automatic step();
        int c, d, f;
        bit hidden, wrap;
        logic [3:0] e_en;
        logic [7:0] e_seg;
        logic [1:0] st_in [4];
        c      = cyc % 8;
        d      = (cyc / 8) % 4;
        f      = cyc / 32;
        hidden = ((f / 2) % 2) == 1;
        wrap   = (cyc % 32) == 31;
        e_en   = 4'hF;
        e_seg  = 8'hFF;
        if (c >= 2 && !m_act_blank[d]) begin
            e_en = ~(4'b0001 << d);
            if (!(m_act_blink[d] && hidden)) e_seg = ~glyph_tab[m_act[d]];
        end
        sb_a.push_back({e_en, e_seg, wrap});
        for (int i = 0; i < 4; i++) st_in[i] = state_a[i*2 +: 2];
        if (wrap) begin
            if (load_a) begin
                for (int i = 0; i < 4; i++) m_act[i] = st_in[i];
                m_act_blank = blank_a;
                m_act_blink = blink_a;
            end else if (m_pend) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_act_blank = m_sh_blank;
                m_act_blink = m_sh_blink;
            end
            m_pend = 1'b0;
        end
        if (load_a) begin
            for (int i = 0; i < 4; i++) m_sh[i] = st_in[i];
            m_sh_blank = blank_a;
            m_sh_blink = blink_a;
            if (!wrap) m_pend = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({en_a, seg_a, fd_a} !== 13'b1111_11111111_0)
            $display("FAIL reset_a: got en=%b seg=%h fd=%b, need en=1111 seg=ff fd=0", en_a, seg_a, fd_a);
        else n_pass++;
        n_total++;
        if ({en_b, seg_b, fd_b} !== 10'b0_00000000_0)
            $display("FAIL reset_b: got en=%b seg=%h fd=%b, need en=0 seg=00 fd=0", en_b, seg_b, fd_b);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        while (cyc < 64) begin
            step();
            exp_v = sb_a.pop_front();
            n_total++;
            if ({en_a, seg_a, fd_a} !== exp_v)
                $display("FAIL dark_idle cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_a, seg_a, fd_a, exp_v[12:9], exp_v[8:1], exp_v[0]);
            else n_pass++;
        end
        $display("reset/idle done at cycle %0d", cyc);
    endtask

    task automatic test_load();
        logic [12:0] exp_v;
        int j;
        while (cyc < 128) begin
            if (cyc == 74) begin
                state_a = 8'b11_10_01_00;
                blank_a = 4'h0;
                blink_a = 4'h0;
                load_a  = 1'b1;
            end
            step();
            load_a = 1'b0;
            exp_v = sb_a.pop_front();
            n_total++;
            if ({en_a, seg_a, fd_a} !== exp_v)
                $display("FAIL load cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_a, seg_a, fd_a, exp_v[12:9], exp_v[8:1], exp_v[0]);
            else n_pass++;
            j = cyc - 1;
            if (j >= 96 && j % 8 == 4) begin
                n_total++;
                if ({en_a, seg_a} !== {en_tab[(j/8)%4], seg_tab[(j/8)%4]})
                    $display("FAIL glyph_digit%0d: got en=%b seg=%h, need en=%b seg=%h",
                             (j/8)%4, en_a, seg_a, en_tab[(j/8)%4], seg_tab[(j/8)%4]);
                else n_pass++;
            end
            if (j >= 96 && j % 8 == 1) begin
                n_total++;
                if (en_a !== 4'hF) $display("FAIL dead_time cyc=%0d: got en=%b, need en=1111", cyc, en_a);
                else n_pass++;
            end
        end
        $display("load done at cycle %0d", cyc);
    endtask

    task automatic test_midframe();
        logic [12:0] exp_v;
        int j;
        while (cyc < 192) begin
            if (cyc == 138) begin
                state_a = 8'hFF;
                load_a  = 1'b1;
            end
            step();
            load_a = 1'b0;
            exp_v = sb_a.pop_front();
            n_total++;
            if ({en_a, seg_a, fd_a} !== exp_v)
                $display("FAIL midframe cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_a, seg_a, fd_a, exp_v[12:9], exp_v[8:1], exp_v[0]);
            else n_pass++;
            j = cyc - 1;
            if (j == 148 || j == 156) begin
                n_total++;
                if (seg_a !== seg_tab[(j/8)%4])
                    $display("FAIL midframe_hold cyc=%0d: got seg=%h, need seg=%h", cyc, seg_a, seg_tab[(j/8)%4]);
                else n_pass++;
            end
            if (j >= 160 && j % 8 == 4) begin
                n_total++;
                if (seg_a !== 8'hB0) $display("FAIL midframe_next cyc=%0d: got seg=%h, need seg=b0", cyc, seg_a);
                else n_pass++;
            end
        end
        $display("midframe done at cycle %0d", cyc);
    endtask

    task automatic test_blink();
        logic [12:0] exp_v;
        int j;
        logic [7:0] want;
        while (cyc < 384) begin
            if (cyc == 192) begin
                state_a = 8'b11_10_01_00;
                blink_a = 4'b0100;
                load_a  = 1'b1;
            end
            step();
            load_a = 1'b0;
            exp_v = sb_a.pop_front();
            n_total++;
            if ({en_a, seg_a, fd_a} !== exp_v)
                $display("FAIL blink cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_a, seg_a, fd_a, exp_v[12:9], exp_v[8:1], exp_v[0]);
            else n_pass++;
            j = cyc - 1;
            if (j >= 224 && j % 32 == 20) begin
                want = (((j / 32) / 2) % 2 == 1) ? 8'hFF : 8'hA4;
                n_total++;
                if ({en_a, seg_a} !== {4'b1011, want})
                    $display("FAIL blink_digit2 frame=%0d: got en=%b seg=%h, need en=1011 seg=%h",
                             j / 32, en_a, seg_a, want);
                else n_pass++;
            end
        end
        $display("blink done at cycle %0d", cyc);
    endtask

    task automatic test_wrap_load();
        logic [12:0] exp_v;
        while (cyc < 430) begin
            if (cyc == 415) begin
                state_a = 8'b01_01_01_01;
                blink_a = 4'h0;
                load_a  = 1'b1;
            end
            step();
            load_a = 1'b0;
            exp_v = sb_a.pop_front();
            n_total++;
            if ({en_a, seg_a, fd_a} !== exp_v)
                $display("FAIL wrap_load cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_a, seg_a, fd_a, exp_v[12:9], exp_v[8:1], exp_v[0]);
            else n_pass++;
            if (cyc == 420) begin
                n_total++;
                if ({en_a, seg_a} !== {4'b1110, 8'hF9})
                    $display("FAIL wrap_bypass: got en=%b seg=%h, need en=1110 seg=f9", en_a, seg_a);
                else n_pass++;
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({en_a, seg_a, fd_a} !== 13'b1111_11111111_0)
            $display("FAIL async_reset: got en=%b seg=%h fd=%b, need en=1111 seg=ff fd=0", en_a, seg_a, fd_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("wrap load and async reset done");
    endtask

    task automatic test_single_digit();
        logic [9:0] exp_v;
        bit e_on;
        while (cyc < 40) begin
            e_on = (cyc >= 8) && (cyc % 8 >= 2);
            sb_b.push_back({e_on, e_on ? 8'h77 : 8'h00, (cyc % 8) == 7});
            if (cyc == 2) begin
                state_b = 4'hA;
                blank_b = 1'b0;
                blink_b = 1'b0;
                load_b  = 1'b1;
            end
            step();
            load_b = 1'b0;
            exp_v = sb_b.pop_front();
            n_total++;
            if ({en_b, seg_b, fd_b} !== exp_v)
                $display("FAIL single_digit cyc=%0d: got en=%b seg=%h fd=%b, need en=%b seg=%h fd=%b",
                         cyc, en_b, seg_b, fd_b, exp_v[9], exp_v[8:1], exp_v[0]);
            else n_pass++;
        end
        sb_a.delete();
        $display("single digit done at cycle %0d", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_midframe();
        test_blink();
        test_wrap_load();
        test_single_digit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
